// File: rtl/tx_feeder_fifo_pkg.sv
// Shared constants for the UART transmit feeder: default widths and FSM encoding.
package tx_feeder_fifo_pkg;

  localparam int unsigned DATA_BITS_DEF = 8;
  localparam int unsigned ADDR_BITS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'b001,
    START     = 3'b010,
    WAIT_DONE = 3'b100
  } feeder_state_e;

endpackage

// File: rtl/tx_feeder_fifo_if.sv
// Producer/transmitter-facing signal bundle of the transmit feeder FIFO.
interface tx_feeder_fifo_if
  import tx_feeder_fifo_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) ();

  logic                 i_wr;
  logic [DATA_BITS-1:0] i_wr_data;
  logic                 o_full;
  logic                 o_empty;
  logic [ADDR_BITS:0]   o_count;
  logic                 o_overflow;
  logic [DATA_BITS-1:0] o_tx_data;
  logic                 o_tx_start;
  logic                 i_tx_done;
  logic                 o_busy;

  // Driven by producers and the transmitter
  modport master (
    output i_wr, i_wr_data, i_tx_done,
    input  o_full, o_empty, o_count, o_overflow, o_tx_data, o_tx_start, o_busy
  );

  // Implemented by the feeder FIFO
  modport slave (
    input  i_wr, i_wr_data, i_tx_done,
    output o_full, o_empty, o_count, o_overflow, o_tx_data, o_tx_start, o_busy
  );

endinterface

// File: rtl/tx_feeder_fifo_fifo_sync.sv
// Synchronous FIFO storage: count-based full/empty, sticky overflow, combinational read port.
module fifo_sync #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_rd_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_overflow
);

  localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
  localparam int unsigned CNT_BITS = ADDR_BITS + 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0]  count;
  logic [CNT_BITS-1:0]  count_nxt;
  logic                 full_q;
  logic                 empty_q;
  logic                 overflow_q;
  logic                 push_ok_c;
  logic                 pop_ok_c;

  assign push_ok_c = i_push && !full_q;
  assign pop_ok_c  = i_pop && !empty_q;

  always_comb begin
    count_nxt = count;
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_nxt = count + CNT_BITS'(1);
      2'b01:   count_nxt = count - CNT_BITS'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are registered from the next count so they always agree with o_count
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + ADDR_BITS'(1);
      count      <= count_nxt;
      full_q     <= (count_nxt == CNT_BITS'(DEPTH));
      empty_q    <= (count_nxt == '0);
      overflow_q <= overflow_q | (i_push & full_q);
    end
  end

  // Storage carries no reset; contents are don't-care until written
  always_ff @(posedge i_clock) begin
    if (push_ok_c) mem[wr_ptr] <= i_wr_data;
  end

  assign o_rd_data  = mem[rd_ptr];
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count;
  assign o_overflow = overflow_q;

endmodule

// File: rtl/tx_feeder_fifo.sv
// Transmit feeder: buffers producer bytes and issues them one at a time to the UART transmitter.
module tx_feeder_fifo
  import tx_feeder_fifo_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic           i_clock,
  input  logic           i_reset,
  tx_feeder_fifo_if.slave bus
);

  feeder_state_e        state;
  feeder_state_e        state_nxt;
  logic                 pop_c;
  logic [DATA_BITS-1:0] rd_data;
  logic [DATA_BITS-1:0] tx_data_q;
  logic                 tx_start_q;
  logic                 busy_q;

  fifo_sync #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_push     (bus.i_wr),
    .i_wr_data  (bus.i_wr_data),
    .i_pop      (pop_c),
    .o_rd_data  (rd_data),
    .o_full     (bus.o_full),
    .o_empty    (bus.o_empty),
    .o_count    (bus.o_count),
    .o_overflow (bus.o_overflow)
  );

  // Next-state and pop decode; done pulses outside WAIT_DONE are ignored
  always_comb begin
    state_nxt = IDLE;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.o_empty) begin
          pop_c     = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: state_nxt = bus.i_tx_done ? IDLE : WAIT_DONE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Start and busy are registered decodes of the state being entered
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_start_q <= (state_nxt == START);
      busy_q     <= (state_nxt != IDLE);
      if (pop_c) tx_data_q <= rd_data;
    end
  end

  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_tx_feeder_fifo.sv
// Scenario bench for tx_feeder_fifo against a queue-based reference model.
module tb_tx_feeder_fifo;
  import tx_feeder_fifo_pkg::*;

  localparam int unsigned DW      = DATA_BITS_DEF;
  localparam int unsigned AW      = ADDR_BITS_DEF;
  localparam int          DEPTH_I = 2 ** AW;

  logic i_clock = 1'b0;
  logic i_reset = 1'b0;

  tx_feeder_fifo_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

  tx_feeder_fifo #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clock = ~i_clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stored words, transmitter phase (0 idle, 1 start, 2 waiting), last issued word
  logic [DW-1:0] mq[$];
  int            m_phase;
  logic [DW-1:0] m_data;
  logic          m_ovf;

  function automatic void model_reset();
    mq.delete();
    m_phase = 0;
    m_data  = '0;
    m_ovf   = 1'b0;
  endfunction

  function automatic void model_step(input logic wr, input logic [DW-1:0] d, input logic done);
    bit pop;
    bit full;
    pop  = (m_phase == 0) && (mq.size() != 0);
    full = (mq.size() == DEPTH_I);
    if (pop) m_data = mq.pop_front();
    if (wr && !full) mq.push_back(d);
    if (wr && full) m_ovf = 1'b1;
    case (m_phase)
      0:       m_phase = pop ? 1 : 0;
      1:       m_phase = 2;
      default: m_phase = done ? 0 : 2;
    endcase
  endfunction

  task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic done);
    bus.i_wr      = wr;
    bus.i_wr_data = d;
    bus.i_tx_done = done;
    model_step(wr, d, done);
    @(posedge i_clock);
    #1;
    bus.i_wr      = 1'b0;
    bus.i_tx_done = 1'b0;
  endtask

  task automatic apply_reset();
    i_reset = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", bus.o_empty); end
    n_tests++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b exp=0", bus.o_full); end
    n_tests++; if (bus.o_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.o_count); end
    n_tests++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%0b exp=0", bus.o_overflow); end
    n_tests++; if (bus.o_tx_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=00", bus.o_tx_data); end
    n_tests++; if (bus.o_tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%0b exp=0", bus.o_tx_start); end
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", bus.o_busy); end
  endtask

  task automatic test_single();
    apply_reset();
    cycle(1'b1, DW'(8'hA5), 1'b0);
    n_tests++; if (bus.o_count !== 5'd1) begin n_fail++; $display("FAIL single_count_c1 got=%0d exp=1", bus.o_count); end
    n_tests++; if (bus.o_tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_c1 got=%0b exp=0", bus.o_tx_start); end
    cycle(1'b0, '0, 1'b0);
    n_tests++; if (bus.o_tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start_c2 got=%0b exp=1", bus.o_tx_start); end
    n_tests++; if (bus.o_tx_data !== DW'(8'hA5)) begin n_fail++; $display("FAIL single_data got=%h exp=a5", bus.o_tx_data); end
    n_tests++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c2 got=%0b exp=1", bus.o_busy); end
    n_tests++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL single_count_c2 got=%0d exp=0", bus.o_count); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0);
      n_tests++; if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) begin
        n_fail++; $display("FAIL single_wait start=%0b busy=%0b exp start=0 busy=1", bus.o_tx_start, bus.o_busy);
      end
    end
    cycle(1'b0, '0, 1'b1);
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_done got=%0b exp=0", bus.o_busy); end
    n_tests++; if (bus.o_tx_data !== DW'(8'hA5)) begin n_fail++; $display("FAIL single_data_held got=%h exp=a5", bus.o_tx_data); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words[3];
    int            n_starts;
    int            cyc;
    int            done_at;
    int            last_done;
    logic          do_done;
    words[0] = DW'(8'h11); words[1] = DW'(8'h22); words[2] = DW'(8'h33);
    apply_reset();
    cyc = 0; done_at = -1; last_done = -1; n_starts = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, words[i], 1'b0);
      cyc++;
      if (bus.o_tx_start === 1'b1) begin
        n_tests++; if (bus.o_tx_data !== words[n_starts]) begin n_fail++; $display("FAIL b2b_word%0d got=%h exp=%h", n_starts, bus.o_tx_data, words[n_starts]); end
        n_starts++; done_at = cyc + 50;
      end
    end
    while (n_starts < 3 && cyc < 400) begin
      do_done = (cyc == done_at);
      cycle(1'b0, '0, do_done);
      if (do_done) last_done = cyc;
      cyc++;
      if (bus.o_tx_start === 1'b1) begin
        n_tests++; if (bus.o_tx_data !== words[n_starts]) begin n_fail++; $display("FAIL b2b_word%0d got=%h exp=%h", n_starts, bus.o_tx_data, words[n_starts]); end
        if (n_starts > 0) begin
          n_tests++; if (cyc - last_done != 2) begin n_fail++; $display("FAIL b2b_gap%0d got=%0d exp=2", n_starts, cyc - last_done); end
        end
        n_starts++; done_at = cyc + 50;
      end
    end
    n_tests++; if (n_starts != 3) begin n_fail++; $display("FAIL b2b_starts got=%0d exp=3", n_starts); end
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] w[17];
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      w[i] = DW'($urandom);
      cycle(1'b1, w[i], 1'b0);
    end
    n_tests++; if (bus.o_count !== 5'd16) begin n_fail++; $display("FAIL fill_count got=%0d exp=16", bus.o_count); end
    n_tests++; if (bus.o_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%0b exp=1", bus.o_full); end
    n_tests++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early got=%0b exp=0", bus.o_overflow); end
    n_tests++; if (bus.o_tx_data !== w[0]) begin n_fail++; $display("FAIL fill_first got=%h exp=%h", bus.o_tx_data, w[0]); end
    cycle(1'b1, DW'(8'hEE), 1'b0);
    n_tests++; if (bus.o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%0b exp=1", bus.o_overflow); end
    n_tests++; if (bus.o_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got=%0d exp=16", bus.o_count); end
    // Done and a write in the same cycle while full: write is still dropped
    cycle(1'b1, DW'(8'hDD), 1'b1);
    n_tests++; if (bus.o_count !== 5'd16 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL full_done count=%0d busy=%0b exp count=16 busy=0", bus.o_count, bus.o_busy);
    end
    cycle(1'b0, '0, 1'b0);
    n_tests++; if (bus.o_count !== 5'd15) begin n_fail++; $display("FAIL full_done_pop got=%0d exp=15", bus.o_count); end
    n_tests++; if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== w[1]) begin
      n_fail++; $display("FAIL full_done_word start=%0b data=%h exp start=1 data=%h", bus.o_tx_start, bus.o_tx_data, w[1]);
    end
    for (int k = 2; k < 17; k++) begin
      cycle(1'b0, '0, 1'b0);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);
      n_tests++; if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== w[k]) begin
        n_fail++; $display("FAIL drain%0d start=%0b data=%h exp start=1 data=%h", k, bus.o_tx_start, bus.o_tx_data, w[k]);
      end
    end
    n_tests++; if (bus.o_empty !== 1'b1 || bus.o_overflow !== 1'b1) begin
      n_fail++; $display("FAIL drain_end empty=%0b ovf=%0b exp empty=1 ovf=1", bus.o_empty, bus.o_overflow);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] d;
    logic          wr;
    logic          done;
    int            done_cd;
    int            cyc;
    int            max_count;
    apply_reset();
    done_cd = -1; cyc = 0; max_count = 0;
    while (got.size() < 40 && cyc < 3000) begin
      wr   = (sent.size() < 40) && (mq.size() < DEPTH_I) && ($urandom_range(0, 2) != 0);
      d    = DW'($urandom);
      done = (done_cd == 0) || (m_phase == 0 && $urandom_range(0, 7) == 0);
      cycle(wr, d, done);
      cyc++;
      if (wr) sent.push_back(d);
      if (done_cd == 0) done_cd = -1;
      else if (done_cd > 0) done_cd--;
      if (int'(bus.o_count) > max_count) max_count = int'(bus.o_count);
      n_tests++; if (int'(bus.o_count) != mq.size() || bus.o_full !== (mq.size() == DEPTH_I) ||
                     bus.o_empty !== (mq.size() == 0)) begin
        n_fail++; $display("FAIL wrap_count c%0d count=%0d full=%0b empty=%0b exp count=%0d", cyc, bus.o_count, bus.o_full, bus.o_empty, mq.size());
      end
      n_tests++; if (bus.o_tx_start !== (m_phase == 1) || bus.o_busy !== (m_phase != 0) || bus.o_overflow !== m_ovf) begin
        n_fail++; $display("FAIL wrap_ctrl c%0d start=%0b busy=%0b ovf=%0b exp phase=%0d ovf=%0b", cyc, bus.o_tx_start, bus.o_busy, bus.o_overflow, m_phase, m_ovf);
      end
      n_tests++; if (bus.o_tx_data !== m_data) begin n_fail++; $display("FAIL wrap_data c%0d got=%h exp=%h", cyc, bus.o_tx_data, m_data); end
      if (bus.o_tx_start === 1'b1) begin
        got.push_back(bus.o_tx_data);
        done_cd = $urandom_range(1, 8);
      end
    end
    n_tests++; if (got.size() != 40) begin n_fail++; $display("FAIL wrap_total got=%0d exp=40", got.size()); end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      n_tests++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL wrap_order%0d got=%h exp=%h", i, got[i], sent[i]); end
    end
    n_tests++; if (max_count > DEPTH_I) begin n_fail++; $display("FAIL wrap_maxcount got=%0d exp<=%0d", max_count, DEPTH_I); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'($urandom), 1'b0);
    n_tests++; if (bus.o_count !== 5'd5 || bus.o_busy !== 1'b1 || bus.o_tx_start !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre count=%0d busy=%0b start=%0b exp 5/1/0", bus.o_count, bus.o_busy, bus.o_tx_start);
    end
    i_reset = 1'b0;
    #1;
    n_tests++; if (bus.o_count !== '0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_fifo count=%0d empty=%0b full=%0b ovf=%0b exp 0/1/0/0", bus.o_count, bus.o_empty, bus.o_full, bus.o_overflow);
    end
    n_tests++; if (bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0 || bus.o_tx_data !== '0) begin
      n_fail++; $display("FAIL mid_async_tx busy=%0b start=%0b data=%h exp 0/0/00", bus.o_busy, bus.o_tx_start, bus.o_tx_data);
    end
    model_reset();
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_count !== '0 || bus.o_empty !== 1'b1) begin
        n_fail++; $display("FAIL mid_after%0d start=%0b busy=%0b count=%0d empty=%0b exp 0/0/0/1", i, bus.o_tx_start, bus.o_busy, bus.o_count, bus.o_empty);
      end
      cycle(1'b0, '0, 1'b0);
    end
  endtask

  initial begin
    bus.i_wr      = 1'b0;
    bus.i_wr_data = '0;
    bus.i_tx_done = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_feeder_fifo.md
Name: tx_feeder_fifo

Overview:
- Buffers bytes produced by upstream logic (ALU result path, PC-side command generator) and hands them one at a time to the UART transmitter.
- Sits directly upstream of the transmitter. Drives its data and start inputs, and consumes its one-cycle "transmission finished" pulse.
- Lets producers burst up to DEPTH bytes without waiting on the serial line.

Parameters:
- DATA_BITS, 8, width of each buffered word; must match the transmitter data width.
- ADDR_BITS, 4, FIFO address width; DEPTH = 2**ADDR_BITS (default 16 entries).

Ports:
- i_clock  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously to i_clock.
- i_wr  in  1  write strobe; one word is offered per cycle while high.
- i_wr_data  in  DATA_BITS  word to buffer, sampled when i_wr=1.
- o_full  out  1  FIFO holds DEPTH words.
- o_empty  out  1  FIFO holds 0 words.
- o_count  out  ADDR_BITS+1  number of stored words, 0..DEPTH.
- o_overflow  out  1  sticky flag: a write was dropped because the FIFO was full.
- o_tx_data  out  DATA_BITS  word presented to the transmitter.
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- i_tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- o_busy  out  1  a word has been issued and its i_tx_done has not yet been seen.

Behaviour:
- Reset (i_reset=0, async): pointers and count = 0; o_empty=1; o_full=0; o_overflow=0; o_tx_data=0; o_tx_start=0; o_busy=0; FSM = IDLE. Memory contents are don't-care.
- Write acceptance:
  - A write is accepted iff i_wr=1 and o_full=0, evaluated on the pre-edge count.
  - The word is stored at wr_ptr; wr_ptr increments mod DEPTH.
  - i_wr=1 while full: the word is dropped, pointers are unchanged, and o_overflow is set to 1. o_overflow clears only on reset.
- Pop: happens only in IDLE when o_empty=0. mem[rd_ptr] is registered into o_tx_data, and rd_ptr increments mod DEPTH.
- Count arithmetic:
  - Accepted write with no pop: count+1.
  - Pop with no accepted write: count-1.
  - Both in the same cycle: count unchanged.
  - o_full = (count==DEPTH); o_empty = (count==0). Both are derived from the registered count.
- No fall-through: a word written into an empty FIFO at cycle N is counted at N+1, popped at N+1, and o_tx_start is high at N+2.
- Pointer wrap: both pointers are ADDR_BITS wide and wrap naturally. Full/empty come from count only, never from pointer equality.
- FSM, one-hot, 3 states:
  - IDLE: o_busy=0. If o_empty=0: pop and go to START. Otherwise stay.
  - START: o_tx_start=1 for exactly this cycle; o_busy=1; o_tx_data is valid and held. Go to WAIT_DONE unconditionally.
  - WAIT_DONE: o_busy=1. o_tx_data is held stable until the next pop. On i_tx_done=1 go to IDLE; otherwise stay.
  - Illegal encoding: go to IDLE with o_tx_start=0.
- o_tx_start is a registered decode of state==START and is never high for two consecutive cycles.
- i_tx_done in IDLE or START is ignored; it has no effect on state or counters.
- Back-to-back transfers: i_tx_done at cycle K gives IDLE at K+1; a pop at K+1 if non-empty; start at K+2. The transmitter is already idle at K+1, so no start is lost.
- Writes continue in every FSM state, including while a word is in flight.
- Reset mid-transfer: the in-flight word is lost and all FIFO contents are discarded. A stale i_tx_done after reset is ignored because the FSM is in IDLE.

Decomposition:
- Shared package holds:
  - FSM state constants: IDLE=3'b001, START=3'b010, WAIT_DONE=3'b100.
  - The default DATA_BITS / ADDR_BITS values, so they are shared with the transmitter instance.
- One sub-module, fifo_sync:
  - Parameterised storage with pointers, count, full/empty and overflow.
  - Push/pop strobe interface; read data is mem[rd_ptr] combinationally.
- The top level holds the FSM and the o_tx_data / o_tx_start registers.

Test Plan:
- Reset then single write 0xA5 at cycle 0 -> o_count=1 at cycle 1; o_tx_start=1 only at cycle 2 with o_tx_data=0xA5; o_busy=1 from cycle 2 until the cycle after i_tx_done; o_count=0 from cycle 2.
- Write 3 words 0x11, 0x22, 0x33 back-to-back; pulse i_tx_done 50 cycles after each start -> three starts in order 0x11, 0x22, 0x33; each start follows its preceding done by exactly 2 cycles.
- Write 17 words with no done pulses (DEPTH=16) -> 1 word popped into the FSM, o_full=1 after 16 stored, o_count=16. A further write sets o_overflow=1 and leaves the pointers unchanged.
- FIFO full with i_tx_done and a new write in the same cycle -> the write is dropped (full on pre-edge count) and o_overflow=1; the next cycle pops, giving o_count=15.
- Wrap-around: 40 writes interleaved with dones, with a transmitter model in loop -> output sequence equals input sequence exactly; o_count never exceeds 16.
- Assert i_reset=0 during WAIT_DONE with 5 words queued, then pulse i_tx_done after release -> all outputs take their reset values immediately; no o_tx_start occurs; o_count=0.
